// File: rtl/dbuf_pwr_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbuf_pwr_seq : staggered enable sequencer for a bank of dbuf bricks
// Revision     : 1.0
// ---------------------------------------------------------------------------
module dbuf_pwr_seq #(
  parameter int NBUF   = 4,
  parameter int SETTLE = 8,
  parameter int CW     = 4
) (
  input  logic            CELCLK,
  input  logic            CELRST,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            SUB,
  input  logic            pwr_req,
  input  logic            fault,
  output logic [NBUF-1:0] en,
  output logic            pwr_ack,
  output logic            busy,
  output logic            fault_flag
);

  localparam int SW = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(SETTLE - 1);
  localparam logic [SW-1:0]   LAST   = SW'(NBUF - 1);
  localparam logic [NBUF-1:0] FIRST  = NBUF'(1);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_RAMP_UP = 3'd1,
    S_ON      = 3'd2,
    S_RAMP_DN = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [NBUF-1:0] en_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [SW-1:0]   stage, stage_nx;
  logic            ack_nx, busy_nx, flag_nx;

  // Rail pins are carried for netlist connectivity only.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state      <= S_OFF;
      en         <= '0;
      cnt        <= '0;
      stage      <= '0;
      pwr_ack    <= 1'b0;
      busy       <= 1'b0;
      fault_flag <= 1'b0;
    end else begin
      state      <= state_nx;
      en         <= en_nx;
      cnt        <= cnt_nx;
      stage      <= stage_nx;
      pwr_ack    <= ack_nx;
      busy       <= busy_nx;
      fault_flag <= flag_nx;
    end
  end

  always_comb begin
    state_nx = state;
    en_nx    = en;
    cnt_nx   = cnt;
    stage_nx = stage;
    ack_nx   = pwr_ack;
    busy_nx  = busy;
    flag_nx  = fault_flag;

    if (fault) begin
      state_nx = S_FAULT;
      en_nx    = '0;
      cnt_nx   = '0;
      stage_nx = '0;
      ack_nx   = 1'b0;
      busy_nx  = 1'b0;
      flag_nx  = 1'b1;
    end else begin
      case (state)
        S_OFF: begin
          if (pwr_req) begin
            state_nx = S_RAMP_UP;
            en_nx    = FIRST;
            cnt_nx   = RELOAD;
            stage_nx = '0;
            busy_nx  = 1'b1;
          end
        end
        S_RAMP_UP: begin
          // A request drop takes precedence over a same-cycle step.
          if (!pwr_req) begin
            state_nx = S_RAMP_DN;
            en_nx    = en >> 1;
            stage_nx = (stage == '0) ? '0 : stage - 1'b1;
            cnt_nx   = RELOAD;
          end else if (cnt != '0) begin
            cnt_nx = cnt - 1'b1;
          end else if (stage == LAST) begin
            state_nx = S_ON;
            ack_nx   = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            en_nx    = (en << 1) | FIRST;
            stage_nx = stage + 1'b1;
            cnt_nx   = RELOAD;
          end
        end
        S_ON: begin
          if (!pwr_req) begin
            state_nx = S_RAMP_DN;
            en_nx    = en >> 1;
            stage_nx = (stage == '0) ? '0 : stage - 1'b1;
            cnt_nx   = RELOAD;
            ack_nx   = 1'b0;
            busy_nx  = 1'b1;
          end
        end
        S_RAMP_DN: begin
          // Once en is empty, one more full interval elapses before OFF.
          if (cnt != '0) begin
            cnt_nx = cnt - 1'b1;
          end else if (en == '0) begin
            state_nx = S_OFF;
            busy_nx  = 1'b0;
          end else begin
            en_nx    = en >> 1;
            stage_nx = (stage == '0) ? '0 : stage - 1'b1;
            cnt_nx   = RELOAD;
          end
        end
        S_FAULT: begin
          if (!pwr_req) begin
            state_nx = S_OFF;
            flag_nx  = 1'b0;
          end
        end
        default: begin
          state_nx = S_OFF;
          en_nx    = '0;
          cnt_nx   = '0;
          stage_nx = '0;
          ack_nx   = 1'b0;
          busy_nx  = 1'b0;
          flag_nx  = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbuf_pwr_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dbuf_pwr_seq : scoreboard bench with a time-based reference model
// Revision        : 1.1
// ---------------------------------------------------------------------------
module tb_dbuf_pwr_seq;

    localparam int NB   = 4;
    localparam int ST   = 8;
    localparam int WDOG = 20000;

    localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DN = 3, M_FLT = 4;

    typedef struct packed {
        logic [NB-1:0] en;
        logic          ack;
        logic          busy;
        logic          flag;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic flt = 1'b0;
    logic [NB-1:0] en;
    logic pwr_ack, busy, fault_flag;

    int   checks = 0;
    int   fails  = 0;
    bit   done   = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    dbuf_pwr_seq #(.NBUF(NB), .SETTLE(ST), .CW(4)) dut (
        .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .pwr_req(req), .fault(flt),
        .en(en), .pwr_ack(pwr_ack), .busy(busy), .fault_flag(fault_flag)
    );

    int  mode = M_OFF;
    int  t0 = 0, l0 = 0, cyc = 0;
    bit  started = 0;

    function automatic logic [NB-1:0] therm(input int lvl);
        logic [NB-1:0] v = '0;
        for (int i = 0; i < NB; i++) if (i < lvl) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int up_lvl(input int e, input int s);
        int l = 1 + (e - s) / ST;
        return (l > NB) ? NB : l;
    endfunction

    function automatic int dn_lvl(input int e, input int s, input int l_start);
        int l = l_start - 1 - (e - s) / ST;
        return (l < 0) ? 0 : l;
    endfunction

    initial begin : model
        obs_t o;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mode = M_OFF;
                started = 1;
            end else if (started) begin
                if (flt) mode = M_FLT;
                else begin
                    case (mode)
                        M_OFF: if (req) begin mode = M_UP; t0 = cyc; end
                        M_UP: begin
                            if (!req) begin
                                l0 = up_lvl(cyc - 1, t0);
                                mode = M_DN; t0 = cyc;
                            end else if (cyc - t0 >= NB * ST) mode = M_ON;
                        end
                        M_ON: if (!req) begin mode = M_DN; l0 = NB; t0 = cyc; end
                        M_DN: if (cyc - t0 >= l0 * ST) mode = M_OFF;
                        M_FLT: if (!req) mode = M_OFF;
                        default: mode = M_OFF;
                    endcase
                end
            end
            if (started) begin
                o = '0;
                case (mode)
                    M_UP:  begin o.en = therm(up_lvl(cyc, t0)); o.busy = 1'b1; end
                    M_ON:  begin o.en = '1; o.ack = 1'b1; end
                    M_DN:  begin o.en = therm(dn_lvl(cyc, t0, l0)); o.busy = 1'b1; end
                    M_FLT: o.flag = 1'b1;
                    default: o = '0;
                endcase
                exp_q.push_back(o);
            end
        end
    end

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{en: en, ack: pwr_ack, busy: busy, flag: fault_flag};
                checks++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got en=%b ack=%b busy=%b flag=%b want en=%b ack=%b busy=%b flag=%b",
                             cyc, a.en, a.ack, a.busy, a.flag, e.en, e.ack, e.busy, e.flag);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (WDOG) @(posedge clk);
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL timeout: stimulus did not complete within %0d cycles", WDOG);
            $display("%0d/%0d checks passed", checks - fails, checks);
            $finish;
        end
    end

    task automatic drive(input logic r, input logic q, input logic f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = r; req = q; flt = f;
        end
    endtask

    task automatic check_reset();
        @(posedge clk);
        #1;
        checks++;
        if (en !== '0 || pwr_ack !== 1'b0 || busy !== 1'b0 || fault_flag !== 1'b0) begin
            fails++;
            $display("FAIL reset state: en=%b ack=%b busy=%b flag=%b",
                     en, pwr_ack, busy, fault_flag);
        end
    endtask

    initial begin : stim
        int dur;
        logic rq;
        drive(1, 0, 0, 2);
        check_reset();
        drive(0, 1, 0, 40);
        drive(0, 0, 0, 40);
        drive(0, 1, 0, 12);
        drive(0, 0, 0, 35);
        drive(0, 1, 0, 40);
        drive(0, 1, 1, 1);
        drive(0, 1, 0, 10);
        drive(0, 0, 1, 2);
        drive(0, 0, 0, 3);
        drive(0, 1, 0, 40);
        drive(0, 0, 0, 3);
        drive(0, 1, 0, 60);
        drive(0, 0, 0, 40);
        drive(0, 1, 0, 18);
        drive(1, 1, 0, 1);
        drive(0, 1, 0, 40);
        for (int k = 0; k < 120; k++) begin
            dur = $urandom_range(1, 45);
            rq  = 1'($urandom_range(0, 1));
            for (int i = 0; i < dur; i++)
                drive(($urandom_range(0, 299) == 0), rq, ($urandom_range(0, 89) == 0), 1);
        end
        drive(0, 0, 0, 3);
        @(negedge clk);
        @(negedge clk);
        done = 1;
        if (fails != 0)
            $display("FAIL: %0d of %0d checks failed", fails, checks);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
